// File: rtl/vip_mon_pkg.sv
// Shared types for the Avalon-ST Video sink monitor: FSM states, packet
// type codes and the decoded control-packet field bundle.
package vip_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CTRL,
    CTRL_DRAIN,
    VIDEO,
    USER
  } mon_state_t;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [3:0]  interlace;
  } ctrl_fields_t;

endpackage

// File: rtl/vip_ctrl_nibble_unpack.sv
// Merges the low nibble of each symbol of one control payload beat into the
// partially assembled control fields, selected by payload beat index.
module vip_ctrl_nibble_unpack
  import vip_mon_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic [1:0]                                  beat_idx,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data,
  input  ctrl_fields_t                                cur,
  output ctrl_fields_t                                nxt
);

  logic [3:0] nib [SYMBOLS_PER_BEAT];

  genvar gi;
  generate
    for (gi = 0; gi < SYMBOLS_PER_BEAT; gi++) begin : g_nib
      assign nib[gi] = data[gi*BITS_PER_SYMBOL +: 4];
    end
  endgenerate

  always_comb begin
    nxt = cur;
    case (beat_idx)
      2'd0: begin
        nxt.width[15:12] = nib[0];
        nxt.width[11:8]  = nib[1];
        nxt.width[7:4]   = nib[2];
      end
      2'd1: begin
        nxt.width[3:0]    = nib[0];
        nxt.height[15:12] = nib[1];
        nxt.height[11:8]  = nib[2];
      end
      2'd2: begin
        nxt.height[7:4] = nib[0];
        nxt.height[3:0] = nib[1];
        nxt.interlace   = nib[2];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vip_stream_monitor.sv
// Avalon-ST Video sink monitor: decodes control packets, counts video beats
// and reports size / control / stray-sop violations as registered pulses.
module vip_stream_monitor
  import vip_mon_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int DATA_WIDTH       = 24,
  parameter int CNT_W            = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  output logic                  ready_o,
  output logic [15:0]           width_o,
  output logic [15:0]           height_o,
  output logic [3:0]            interlaced_o,
  output logic                  ctrl_update_o,
  output logic                  frame_done_o,
  output logic [CNT_W-1:0]      beat_cnt_o,
  output logic [CNT_W-1:0]      frame_cnt_o,
  output logic                  err_size_o,
  output logic                  err_ctrl_o,
  output logic                  err_sop_o,
  output logic                  err_sticky_o
);

  generate
    if (BITS_PER_SYMBOL != 8 || SYMBOLS_PER_BEAT != 3 ||
        DATA_WIDTH != BITS_PER_SYMBOL * SYMBOLS_PER_BEAT) begin : g_bad_param
      $error("vip_stream_monitor: only 8 bits x 3 symbols (24-bit data) is supported");
    end
  endgenerate

  mon_state_t   state_reg, state_next;
  logic [1:0]   idx_reg, idx_next;
  ctrl_fields_t pend_reg, pend_next, pend_unpacked;
  ctrl_fields_t fields_reg;
  logic         ctrl_seen_reg;
  logic [CNT_W-1:0] beat_reg, beat_next, beat_inc, frame_beats;
  logic [CNT_W-1:0] beat_cnt_reg, frame_cnt_reg;
  logic         ready_reg, ctrl_upd_reg, frame_done_reg;
  logic         err_size_reg, err_ctrl_reg, err_sop_reg, sticky_reg;
  logic         accept, commit, frame_end;
  logic         err_size_c, err_ctrl_c, err_sop_c;
  logic [31:0]  area;

  assign accept   = valid_i & ready_reg;
  assign beat_inc = (&beat_reg) ? beat_reg : beat_reg + CNT_W'(1);
  assign area     = {16'd0, fields_reg.width} * {16'd0, fields_reg.height};

  vip_ctrl_nibble_unpack #(
    .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
    .SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT)
  ) u_unpack (
    .beat_idx(idx_reg),
    .data    (data_i),
    .cur     (pend_reg),
    .nxt     (pend_unpacked)
  );

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    pend_next   = pend_reg;
    beat_next   = beat_reg;
    frame_beats = beat_reg;
    commit      = 1'b0;
    frame_end   = 1'b0;
    err_ctrl_c  = 1'b0;
    err_sop_c   = 1'b0;
    if (accept) begin
      if (sop_i) begin
        // A sop always starts a fresh packet, even when it interrupts one.
        err_sop_c = (state_reg != IDLE);
        idx_next  = 2'd0;
        beat_next = '0;
        case (data_i[3:0])
          PKT_VIDEO: begin
            state_next = eop_i ? IDLE : VIDEO;
            if (eop_i) begin
              frame_end   = 1'b1;
              frame_beats = '0;
            end
          end
          PKT_CTRL: state_next = eop_i ? IDLE : CTRL;
          default:  state_next = eop_i ? IDLE : USER;
        endcase
      end else begin
        case (state_reg)
          CTRL: begin
            pend_next = pend_unpacked;
            if (idx_reg == 2'd2) begin
              commit     = eop_i;
              state_next = eop_i ? IDLE : CTRL_DRAIN;
            end else if (eop_i) begin
              err_ctrl_c = 1'b1;
              state_next = IDLE;
            end else begin
              idx_next = idx_reg + 2'd1;
            end
          end
          CTRL_DRAIN: begin
            commit = eop_i;
            if (eop_i) state_next = IDLE;
          end
          VIDEO: begin
            beat_next = beat_inc;
            if (eop_i) begin
              frame_end   = 1'b1;
              frame_beats = beat_inc;
              state_next  = IDLE;
            end
          end
          default: if (eop_i) state_next = IDLE;
        endcase
      end
    end
    err_size_c = frame_end && ctrl_seen_reg && (frame_beats != CNT_W'(area));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      idx_reg        <= 2'd0;
      pend_reg       <= '0;
      fields_reg     <= '0;
      ctrl_seen_reg  <= 1'b0;
      beat_reg       <= '0;
      beat_cnt_reg   <= '0;
      frame_cnt_reg  <= '0;
      ready_reg      <= 1'b0;
      ctrl_upd_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      err_size_reg   <= 1'b0;
      err_ctrl_reg   <= 1'b0;
      err_sop_reg    <= 1'b0;
      sticky_reg     <= 1'b0;
    end else begin
      ready_reg      <= enable_i;
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      pend_reg       <= pend_next;
      beat_reg       <= beat_next;
      ctrl_upd_reg   <= commit;
      frame_done_reg <= frame_end;
      err_size_reg   <= err_size_c;
      err_ctrl_reg   <= err_ctrl_c;
      err_sop_reg    <= err_sop_c;
      if (commit) begin
        fields_reg    <= pend_next;
        ctrl_seen_reg <= 1'b1;
      end
      if (frame_end) beat_cnt_reg <= frame_beats;
      if (clear_i)
        frame_cnt_reg <= frame_end ? CNT_W'(1) : '0;
      else if (frame_end)
        frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      // A new error outranks a coincident clear.
      sticky_reg <= err_size_c | err_ctrl_c | err_sop_c | (sticky_reg & ~clear_i);
    end
  end

  assign ready_o       = ready_reg;
  assign width_o       = fields_reg.width;
  assign height_o      = fields_reg.height;
  assign interlaced_o  = fields_reg.interlace;
  assign ctrl_update_o = ctrl_upd_reg;
  assign frame_done_o  = frame_done_reg;
  assign beat_cnt_o    = beat_cnt_reg;
  assign frame_cnt_o   = frame_cnt_reg;
  assign err_size_o    = err_size_reg;
  assign err_ctrl_o    = err_ctrl_reg;
  assign err_sop_o     = err_sop_reg;
  assign err_sticky_o  = sticky_reg;

endmodule

// File: tb/tb_vip_stream_monitor.sv
// Directed bench for vip_stream_monitor: control decode, frame counting,
// size/ctrl/sop errors, enable back-pressure and asynchronous reset.
module tb_vip_stream_monitor;

  logic        clk_i = 1'b0;
  logic        rst_i, enable_i, clear_i, valid_i, sop_i, eop_i;
  logic [23:0] data_i;
  logic        ready_o, ctrl_update_o, frame_done_o;
  logic [15:0] width_o, height_o;
  logic [3:0]  interlaced_o;
  logic [31:0] beat_cnt_o, frame_cnt_o;
  logic        err_size_o, err_ctrl_o, err_sop_o, err_sticky_o;

  int total = 0;
  int bad   = 0;
  int n_ctrl = 0, n_fd = 0, n_esize = 0, n_ectrl = 0, n_esop = 0;
  int b_ctrl, b_fd, b_esize, b_ectrl, b_esop;
  bit tog_stop;

  vip_stream_monitor dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .sop_i        (sop_i),
    .eop_i        (eop_i),
    .ready_o      (ready_o),
    .width_o      (width_o),
    .height_o     (height_o),
    .interlaced_o (interlaced_o),
    .ctrl_update_o(ctrl_update_o),
    .frame_done_o (frame_done_o),
    .beat_cnt_o   (beat_cnt_o),
    .frame_cnt_o  (frame_cnt_o),
    .err_size_o   (err_size_o),
    .err_ctrl_o   (err_ctrl_o),
    .err_sop_o    (err_sop_o),
    .err_sticky_o (err_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  // Pulse tallies; a pulse stuck high for two cycles counts twice.
  always @(negedge clk_i) begin
    n_ctrl  <= n_ctrl  + int'(ctrl_update_o);
    n_fd    <= n_fd    + int'(frame_done_o);
    n_esize <= n_esize + int'(err_size_o);
    n_ectrl <= n_ectrl + int'(err_ctrl_o);
    n_esop  <= n_esop  + int'(err_sop_o);
  end

  task automatic snap();
    b_ctrl = n_ctrl; b_fd = n_fd; b_esize = n_esize; b_ectrl = n_ectrl; b_esop = n_esop;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  // Presents one beat and holds it until the sink accepts it.
  task automatic beat(input logic [23:0] d, input logic s, input logic e);
    int  tries;
    logic acc;
    data_i = d; sop_i = s; eop_i = e; valid_i = 1'b1; tries = 0;
    do begin
      acc = ready_o;
      @(negedge clk_i);
      tries++;
    end while (!acc && tries < 50);
    if (!acc) begin
      total++; bad++;
      $display("FAIL beat_accept_timeout got=not-accepted exp=accepted");
    end
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
  endtask

  function automatic logic [23:0] mk(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] n2);
    return {4'hA, n2, 4'hA, n1, 4'hA, n0};
  endfunction

  // short_at = 0 sends a full control packet, otherwise eop on that payload beat.
  task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il, input int short_at);
    $display("ctrl pkt w=%0d h=%0d il=%0h short_at=%0d", w, h, il, short_at);
    beat(24'h12345F, 1'b1, 1'b0);
    beat(mk(w[15:12], w[11:8], w[7:4]), 1'b0, short_at == 1);
    if (short_at == 1) return;
    beat(mk(w[3:0], h[15:12], h[11:8]), 1'b0, short_at == 2);
    if (short_at == 2) return;
    beat(mk(h[7:4], h[3:0], il), 1'b0, 1'b1);
  endtask

  task automatic vid_sop(input logic e);
    beat(24'h5A5A50, 1'b1, e);
  endtask

  task automatic vid_beats(input int n, input logic last_eop);
    for (int i = 1; i <= n; i++) beat(24'(i), 1'b0, last_eop && (i == n));
  endtask

  task automatic send_video(input int n);
    $display("video pkt beats=%0d", n);
    vid_sop(1'b0);
    vid_beats(n, 1'b1);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", ready_o); end
    total++; if (width_o !== 16'd0 || height_o !== 16'd0 || interlaced_o !== 4'd0) begin
      bad++; $display("FAIL reset_fields got=%0d/%0d/%0h exp=0/0/0", width_o, height_o, interlaced_o); end
    total++; if (beat_cnt_o !== 32'd0 || frame_cnt_o !== 32'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", beat_cnt_o, frame_cnt_o); end
    total++; if ({ctrl_update_o, frame_done_o, err_size_o, err_ctrl_o, err_sop_o, err_sticky_o} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000",
        {ctrl_update_o, frame_done_o, err_size_o, err_ctrl_o, err_sop_o, err_sticky_o}); end
    rst_i = 1'b0; enable_i = 1'b1;
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL ready_latency got=%0b exp=0", ready_o); end
    @(negedge clk_i);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL ready_follow got=%0b exp=1", ready_o); end
  endtask

  task automatic test_ctrl_video();
    snap();
    send_ctrl(16'd800, 16'd600, 4'h3, 0);
    idle(2);
    total++; if (n_ctrl - b_ctrl !== 1) begin bad++; $display("FAIL ctrl_update_count got=%0d exp=1", n_ctrl - b_ctrl); end
    total++; if (width_o !== 16'd800) begin bad++; $display("FAIL ctrl_width got=%0d exp=800", width_o); end
    total++; if (height_o !== 16'd600) begin bad++; $display("FAIL ctrl_height got=%0d exp=600", height_o); end
    total++; if (interlaced_o !== 4'h3) begin bad++; $display("FAIL ctrl_interlace got=%0h exp=3", interlaced_o); end
    send_ctrl(16'd20, 16'd15, 4'h0, 0);
    idle(1);
    snap();
    send_video(300);
    idle(2);
    total++; if (width_o !== 16'd20 || height_o !== 16'd15) begin
      bad++; $display("FAIL ctrl2_fields got=%0d/%0d exp=20/15", width_o, height_o); end
    total++; if (n_fd - b_fd !== 1) begin bad++; $display("FAIL video_frame_done got=%0d exp=1", n_fd - b_fd); end
    total++; if (beat_cnt_o !== 32'd300) begin bad++; $display("FAIL video_beat_cnt got=%0d exp=300", beat_cnt_o); end
    total++; if (frame_cnt_o !== 32'd1) begin bad++; $display("FAIL video_frame_cnt got=%0d exp=1", frame_cnt_o); end
    total++; if (n_esize - b_esize !== 0 || err_sticky_o !== 1'b0) begin
      bad++; $display("FAIL video_no_error got=%0d/%0b exp=0/0", n_esize - b_esize, err_sticky_o); end
  endtask

  task automatic test_size_err();
    snap();
    send_video(299);
    idle(2);
    total++; if (n_esize - b_esize !== 1) begin bad++; $display("FAIL size_err_pulse got=%0d exp=1", n_esize - b_esize); end
    total++; if (err_sticky_o !== 1'b1) begin bad++; $display("FAIL size_sticky got=%0b exp=1", err_sticky_o); end
    total++; if (beat_cnt_o !== 32'd299 || frame_cnt_o !== 32'd2) begin
      bad++; $display("FAIL size_counts got=%0d/%0d exp=299/2", beat_cnt_o, frame_cnt_o); end
    pulse_clear();
    total++; if (err_sticky_o !== 1'b0 || frame_cnt_o !== 32'd0) begin
      bad++; $display("FAIL clear got=%0b/%0d exp=0/0", err_sticky_o, frame_cnt_o); end
  endtask

  task automatic test_ctrl_short();
    snap();
    send_ctrl(16'h1234, 16'h5678, 4'h9, 2);
    idle(2);
    total++; if (n_ectrl - b_ectrl !== 1) begin bad++; $display("FAIL ctrl_short_err got=%0d exp=1", n_ectrl - b_ectrl); end
    total++; if (n_ctrl - b_ctrl !== 0) begin bad++; $display("FAIL ctrl_short_update got=%0d exp=0", n_ctrl - b_ctrl); end
    total++; if (width_o !== 16'd20 || height_o !== 16'd15 || interlaced_o !== 4'h0) begin
      bad++; $display("FAIL ctrl_short_retain got=%0d/%0d/%0h exp=20/15/0", width_o, height_o, interlaced_o); end
    total++; if (err_sticky_o !== 1'b1) begin bad++; $display("FAIL ctrl_short_sticky got=%0b exp=1", err_sticky_o); end
    pulse_clear();
  endtask

  task automatic test_sop_abort();
    snap();
    $display("video pkt interrupted by sop at beat 100");
    vid_sop(1'b0);
    vid_beats(99, 1'b0);
    vid_sop(1'b0);
    idle(2);
    total++; if (n_esop - b_esop !== 1) begin bad++; $display("FAIL sop_err_pulse got=%0d exp=1", n_esop - b_esop); end
    total++; if (n_fd - b_fd !== 0) begin bad++; $display("FAIL sop_abandon_done got=%0d exp=0", n_fd - b_fd); end
    vid_beats(300, 1'b1);
    idle(2);
    total++; if (n_fd - b_fd !== 1 || beat_cnt_o !== 32'd300) begin
      bad++; $display("FAIL sop_new_packet got=%0d/%0d exp=1/300", n_fd - b_fd, beat_cnt_o); end
    total++; if (n_esize - b_esize !== 0 || frame_cnt_o !== 32'd1) begin
      bad++; $display("FAIL sop_new_size got=%0d/%0d exp=0/1", n_esize - b_esize, frame_cnt_o); end
    pulse_clear();
  endtask

  task automatic test_no_ctrl();
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    snap();
    $display("stray beats in idle");
    beat(24'h111111, 1'b0, 1'b0);
    beat(24'h222222, 1'b0, 1'b1);
    send_video(100);
    idle(2);
    total++; if (n_esop + n_ectrl + n_esize - b_esop - b_ectrl - b_esize !== 0 || err_sticky_o !== 1'b0) begin
      bad++; $display("FAIL noctrl_errors got=%0d/%0b exp=0/0",
        n_esop + n_ectrl + n_esize - b_esop - b_ectrl - b_esize, err_sticky_o); end
    total++; if (n_fd - b_fd !== 1 || beat_cnt_o !== 32'd100 || frame_cnt_o !== 32'd1) begin
      bad++; $display("FAIL noctrl_frame got=%0d/%0d/%0d exp=1/100/1", n_fd - b_fd, beat_cnt_o, frame_cnt_o); end
  endtask

  task automatic test_enable_toggle();
    send_ctrl(16'd8, 16'd5, 4'h7, 0);
    idle(1);
    snap();
    tog_stop = 1'b0;
    $display("video pkt beats=40 with enable toggling");
    fork
      begin
        while (!tog_stop) begin
          repeat (3) @(negedge clk_i);
          enable_i = ~enable_i;
        end
      end
      begin
        send_video(40);
        tog_stop = 1'b1;
      end
    join
    enable_i = 1'b1;
    idle(3);
    total++; if (beat_cnt_o !== 32'd40 || n_fd - b_fd !== 1) begin
      bad++; $display("FAIL toggle_beats got=%0d/%0d exp=40/1", beat_cnt_o, n_fd - b_fd); end
    total++; if (n_esize - b_esize !== 0 || frame_cnt_o !== 32'd2) begin
      bad++; $display("FAIL toggle_size got=%0d/%0d exp=0/2", n_esize - b_esize, frame_cnt_o); end
  endtask

  task automatic test_reset_mid();
    $display("partial video pkt then reset");
    vid_sop(1'b0);
    vid_beats(10, 1'b0);
    vid_sop(1'b0);
    vid_beats(5, 1'b0);
    idle(1);
    total++; if (err_sticky_o !== 1'b1 || width_o !== 16'd8) begin
      bad++; $display("FAIL premid_state got=%0b/%0d exp=1/8", err_sticky_o, width_o); end
    rst_i = 1'b1;
    #1;
    total++; if (ready_o !== 1'b0 || err_sticky_o !== 1'b0) begin
      bad++; $display("FAIL rst_async got=%0b/%0b exp=0/0", ready_o, err_sticky_o); end
    total++; if (width_o !== 16'd0 || height_o !== 16'd0 || interlaced_o !== 4'd0 ||
                 beat_cnt_o !== 32'd0 || frame_cnt_o !== 32'd0) begin
      bad++; $display("FAIL rst_outputs got=%0d/%0d/%0h/%0d/%0d exp=0/0/0/0/0",
        width_o, height_o, interlaced_o, beat_cnt_o, frame_cnt_o); end
    @(negedge clk_i); rst_i = 1'b0;
    snap();
    send_video(3);
    idle(2);
    total++; if (beat_cnt_o !== 32'd3 || n_esize - b_esize !== 0 || frame_cnt_o !== 32'd1) begin
      bad++; $display("FAIL post_rst_frame got=%0d/%0d/%0d exp=3/0/1", beat_cnt_o, n_esize - b_esize, frame_cnt_o); end
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0;
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = '0;
    test_reset();
    test_ctrl_video();
    test_size_err();
    test_ctrl_short();
    test_sop_abort();
    test_no_ctrl();
    test_enable_toggle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vip_stream_monitor.md
# vip_stream_monitor

Avalon-ST Video sink-side monitor placed directly downstream of the test-pattern generator top (its data/valid/sop/eop/ready outputs). Decodes packet type and the VIP control packet (width, height, interlace nibble), counts video-packet beats, and flags size and protocol violations. Used as the on-chip check stage in generator bring-up and as the bench scoreboard front-end.

## Interface
- BITS_PER_SYMBOL, 8, symbol width. Only 8 is supported.
- SYMBOLS_PER_BEAT, 3, symbols per beat. Only 3 is supported; elaboration error otherwise.
- DATA_WIDTH, 24, must equal BITS_PER_SYMBOL*SYMBOLS_PER_BEAT.
- CNT_W, 32, width of beat and frame counters.
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  sink enable; drives ready_o.
- clear_i  in  1  synchronous clear of sticky error and frame counter.
- data_i  in  DATA_WIDTH  stream data; symbol 0 in [7:0].
- valid_i, sop_i, eop_i  in  1 each  stream qualifiers.
- ready_o  out  1  sink ready.
- width_o, height_o  out  16 each  last valid control packet fields.
- interlaced_o  out  4  last interlace nibble.
- ctrl_update_o  out  1  one-cycle pulse on valid control packet.
- frame_done_o  out  1  one-cycle pulse at end of video packet.
- beat_cnt_o  out  CNT_W  beat count of last video packet.
- frame_cnt_o  out  CNT_W  completed video packets since reset/clear.
- err_size_o, err_ctrl_o, err_sop_o  out  1 each  one-cycle error pulses.
- err_sticky_o  out  1  OR of all error pulses, held until clear_i.

## Operation
- Beat accepted when valid_i & ready_o. Nothing changes on non-accepted cycles.
- ready_o is a register loaded from enable_i each cycle.
- Packet type is data_i[3:0] of the sop beat. 0 selects video, 0xF selects control, anything else is user (ignored until eop).
- FSM states: IDLE, CTRL, CTRL_DRAIN, VIDEO, USER.
- IDLE: a sop beat moves to the state for its type. A sop beat that also has eop returns to IDLE; a video sop+eop gives frame_done with 0 beats.
- IDLE: a non-sop beat is discarded with no error.
- CTRL collects 3 payload beats, taking the low nibble of each symbol:
  - beat1 gives w[15:12], w[11:8], w[7:4].
  - beat2 gives w[3:0], h[15:12], h[11:8].
  - beat3 gives h[7:4], h[3:0], interlace.
- After beat3: eop goes to IDLE and commits the fields. No eop goes to CTRL_DRAIN, which commits on eop.
- eop before beat3: err_ctrl pulses, fields are not updated, FSM goes to IDLE.
- VIDEO counts payload beats in CNT_W bits, saturating at all-ones.
- On eop in VIDEO: beat_cnt_o takes the count, frame_cnt_o increments (wraps), frame_done_o pulses.
- err_size pulses at that eop if a control packet has been committed since reset and count ≠ width*height. The product is computed as a 32-bit unsigned value from the committed fields.
- sop inside any non-IDLE state:
  - err_sop pulses.
  - The current packet is abandoned: no commit, no frame_done.
  - The new sop beat is decoded as a fresh packet on the same cycle.
- clear_i zeroes err_sticky_o and frame_cnt_o. When coincident with an error pulse, the error wins, so the sticky flag stays set.

## Timing
- Reset values: all outputs 0, FSM in IDLE, "ctrl seen" flag 0.
- All outputs are registered.
- Pulses assert the cycle after the accepted eop/sop beat and last exactly one cycle.
- ready_o follows enable_i with 1-cycle latency. Deasserting enable_i mid-packet pauses the FSM without error.
- Reset mid-packet returns to IDLE and drops partial fields.

## Structure
- Shared package vip_mon_pkg holds:
  - the FSM state enum;
  - packet type constants PKT_VIDEO = 4'h0 and PKT_CTRL = 4'hF;
  - the ctrl field struct (width, height, interlace).
- One sub-module, vip_ctrl_nibble_unpack: combinational nibble extraction per beat index, instantiated once.
- The FSM and counters live in the top.

## Test plan
- Control packet (w=800, h=600, il=0x3), then a video packet of 480000 beats -> ctrl_update once, width_o=800, height_o=600, frame_done, beat_cnt_o=480000, frame_cnt_o=1, no errors.
- Video packet of 479999 beats after that control packet -> err_size pulse, err_sticky_o=1; clear_i -> sticky 0, frame_cnt_o 0.
- Control packet with eop on payload beat 2 -> err_ctrl pulse; width_o/height_o retain previous values.
- sop during a video packet at beat 100 -> err_sop, no frame_done, new packet decoded from that beat.
- Video packet with no prior control packet (100 beats) -> frame_done, beat_cnt_o=100, no err_size.
- valid_i held high while enable_i toggles every 3 cycles -> beat counts include only accepted beats; rst_i pulse mid-packet -> all outputs 0 the next cycle.
